apb_ral_apb_arbiter: RTL and testbench
======================================

Name: apb_ral_apb_arbiter

Overview:
- Round-robin arbiter and APB master sequencer: shares one APB slave (RAM 0x0000-0x0FFF, registers 0x1000/0x1004) between NUM_REQ requesters.
- Each requester issues single read/write commands on a valid/ready port; the block serialises them into APB SETUP/ACCESS transfers and returns a per-requester response pulse.
- Adds a wait-state timeout and rejects misaligned addresses locally, without issuing an APB transfer.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- AW, 16, address width.
- DW, 32, data width.
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout.
- ERR_DATA, 32'h0BADCAFE, rsp_rdata value on timeout or misaligned error.

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  command pending, one bit per requester
- req_write  in  NUM_REQ  1 = write
- req_addr  in  NUM_REQ*AW  packed; requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed; requester i at [i*DW +: DW]
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
- rsp_rdata  out  DW  read data; valid with rsp_valid
- rsp_err  out  1  error flag; valid with rsp_valid
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Single clock pclk; reset synchronous, active-high (preset), wins over all other activity.
- Reset values:
  - state IDLE; every output 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- Every output is driven from a register except req_ready, which is combinational: (state==IDLE) & grant.
- FSM states IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - grant = first i with req_valid[i] set, searching from last+1 with wrap.
  - If there is a grant: assert req_ready[g]; latch g, write, addr, wdata; last <= g.
  - Aligned address (addr[1:0]==0): next state SETUP.
  - Misaligned address: next state RESP with err=1 and rdata=ERR_DATA; no APB activity.
  - No req_valid: stay in IDLE with psel=0.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata from the latch. Lasts exactly 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1; wait counter starts at 0.
  - pready=1: capture prdata (reads only; writes capture 0) and pslverr; go to RESP.
  - pready=0 with TIMEOUT!=0 and counter==TIMEOUT-1: abort, err=1, rdata=ERR_DATA, go to RESP.
  - Otherwise counter++ and stay in ACCESS.
- RESP:
  - psel=0, penable=0; rsp_valid[g]=1 for exactly 1 cycle together with rsp_rdata and rsp_err.
  - Next state IDLE. rsp_rdata/rsp_err hold until the next RESP.
- paddr, pwrite, pwdata hold their last values while psel=0.
- Throughput: one transfer per 4 cycles at zero wait states (IDLE, SETUP, ACCESS, RESP).
- Latency: req_ready to rsp_valid = 3 cycles plus wait states.
- req_valid changing during SETUP or ACCESS has no effect; the command is already latched.
- A requester must not expect acceptance on the same cycle its previous rsp_valid pulses; the earliest next req_ready is the following cycle.
- pslverr is sampled only when penable & pready; it is passed through as rsp_err=1 with rdata=prdata.
- Reset during SETUP or ACCESS:
  - psel/penable are 0 the next cycle.
  - The pending response is dropped; no rsp_valid.
  - The pointer returns to its reset value.

Test Plan:
- Req0 write 0x1000 data 0x00000005, then req0 read 0x1000 -> psel high 1 cycle after req_ready, penable the next cycle; rsp_valid[0] 3 cycles after req_ready; read rsp_rdata=0x00000005, rsp_err=0.
- Both requesters hold req_valid for 4 writes each to RAM 0x0000-0x001C -> req_ready order 0,1,0,1,...; exactly 4 cycles between accepts; each rsp_valid goes to the matching requester.
- Slave holds pready low 3 cycles on a read of 0x0010 containing 0x12345678 (TIMEOUT=16) -> ACCESS lasts 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
- pready tied low, TIMEOUT=8 -> exactly 8 ACCESS cycles, then psel drops; rsp_err=1, rsp_rdata=0x0BADCAFE; the next request proceeds normally.
- Req1 read at 0x1002 -> psel never asserts; rsp_valid[1] 1 cycle after req_ready, rsp_err=1, rsp_rdata=0x0BADCAFE.
- preset asserted during ACCESS of a req1 transfer -> psel=penable=0 the next cycle; no rsp_valid; with both requesters valid after reset, req0 is granted first.

Source files
------------

// File: rtl/apb_ral_apb_arbiter.sv
// apb_ral_apb_arbiter: round-robin arbiter sharing one APB slave
// between NUM_REQ valid/ready requesters, with wait-state timeout.
module apb_ral_apb_arbiter #(
   parameter int              NUM_REQ  = 2,
   parameter int              AW       = 16,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 16,
   parameter logic [DW-1:0]   ERR_DATA = DW'(32'h0BADCAFE)
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [AW-1:0]         paddr,
   output logic [DW-1:0]         pwdata,
   input  logic [DW-1:0]         prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int JW = IW + 1;
   localparam logic [JW-1:0] NR = JW'(NUM_REQ);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IW-1:0]        r_last;
   logic [IW-1:0]        r_gnt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic                 r_psel;
   logic                 r_penable;
   logic                 r_pwrite;
   logic [AW-1:0]        r_paddr;
   logic [DW-1:0]        r_pwdata;
   logic [DW-1:0]        r_rdata;
   logic                 r_err;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic                 w_psel_nxt;
   logic                 w_penable_nxt;
   logic [DW-1:0]        w_rdata_nxt;
   logic                 w_err_nxt;
   logic [NUM_REQ-1:0]   w_rsp_nxt;
   logic                 w_found;
   logic [IW-1:0]        w_gidx;
   logic [JW-1:0]        w_j;
   logic [AW-1:0]        w_gaddr;
   logic [DW-1:0]        w_gwdata;
   logic                 w_gwrite;
   logic                 w_aligned;
   logic                 w_accept;

   // round-robin search starting just after the last granted requester
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_j     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_j = {1'b0, r_last} + JW'(k);
         if (w_j >= NR) w_j = w_j - NR;
         if (!w_found && req_valid[w_j[IW-1:0]]) begin
            w_found = 1'b1;
            w_gidx  = w_j[IW-1:0];
         end
      end
   end

   assign w_gaddr   = req_addr[w_gidx*AW +: AW];
   assign w_gwdata  = req_wdata[w_gidx*DW +: DW];
   assign w_gwrite  = req_write[w_gidx];
   assign w_aligned = (w_gaddr[1:0] == 2'b00);
   assign w_accept  = (r_state == IDLE) && w_found;

   // accept strobe is the only combinational output
   always_comb begin
      req_ready = '0;
      if (w_accept) req_ready[w_gidx] = 1'b1;
   end

   // next-state and next registered outputs of the sequencer
   always_comb begin
      w_state_nxt   = r_state;
      w_psel_nxt    = 1'b0;
      w_penable_nxt = 1'b0;
      w_rsp_nxt     = '0;
      w_rdata_nxt   = r_rdata;
      w_err_nxt     = r_err;
      w_cnt_nxt     = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               if (w_aligned) begin
                  w_state_nxt = SETUP;
                  w_psel_nxt  = 1'b1;
               end else begin
                  w_state_nxt       = RESP;
                  w_rsp_nxt[w_gidx] = 1'b1;
                  w_rdata_nxt       = ERR_DATA;
                  w_err_nxt         = 1'b1;
               end
            end
         end
         SETUP: begin
            w_state_nxt   = ACCESS;
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b1;
            w_cnt_nxt     = '0;
         end
         ACCESS: begin
            if (pready) begin
               w_state_nxt      = RESP;
               w_rsp_nxt[r_gnt] = 1'b1;
               w_rdata_nxt      = r_pwrite ? '0 : prdata;
               w_err_nxt        = pslverr;
            end else if (TO_EN && (r_cnt == CNT_LAST)) begin
               w_state_nxt      = RESP;
               w_rsp_nxt[r_gnt] = 1'b1;
               w_rdata_nxt      = ERR_DATA;
               w_err_nxt        = 1'b1;
            end else begin
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b1;
               w_cnt_nxt     = r_cnt + 1'b1;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // state register and registered bus/response outputs
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state     <= IDLE;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_rsp_valid <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_psel      <= w_psel_nxt;
         r_penable   <= w_penable_nxt;
         r_rsp_valid <= w_rsp_nxt;
         r_rdata     <= w_rdata_nxt;
         r_err       <= w_err_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   // command latch; APB fields only move when a transfer will run
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_last   <= LAST_RST;
         r_gnt    <= '0;
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
      end else if (w_accept) begin
         r_last <= w_gidx;
         r_gnt  <= w_gidx;
         if (w_aligned) begin
            r_pwrite <= w_gwrite;
            r_paddr  <= w_gaddr;
            r_pwdata <= w_gwdata;
         end
      end
   end

   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_ral_apb_arbiter.sv
// tb_apb_ral_apb_arbiter: scoreboard bench with an APB slave model
// and a transaction-level reference of arbitration and responses.
module tb_apb_ral_apb_arbiter;

   localparam int NR = 2;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam logic [31:0] ERRD = 32'h0BADCAFE;

   logic             pclk = 1'b0;
   logic             preset = 1'b1;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_write;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic [DW-1:0]    prdata = '0;
   logic             pready = 1'b0;
   logic             pslverr = 1'b0;

   always #5 pclk = ~pclk;

   apb_ral_apb_arbiter #(
      .NUM_REQ (NR),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          gap;
   } cmd_t;

   typedef struct {
      int          req;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          waits;
      int          scyc;
   } apb_t;

   cmd_t        cq [NR][$];
   exp_t        eq [$];
   apb_t        sq [$];
   apb_t        cur;
   logic [31:0] ref_mem [int];
   logic [31:0] smem [0:1025];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ptr = NR - 1;
   int force_waits = 0;
   int last_acc = -1;
   int acc = 0;
   bit busy = 1'b0;
   bit spacing_chk = 1'b0;
   bit prev_setup = 1'b0;

   logic          tv [NR];
   logic          tw [NR];
   logic [AW-1:0] ta [NR];
   logic [DW-1:0] td [NR];

   always_comb begin
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = tv[i];
         req_write[i]         = tw[i];
         req_addr[i*AW +: AW] = ta[i];
         req_wdata[i*DW +: DW] = td[i];
      end
   end

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
      end
   endtask

   task automatic fail(string nm);
      checks++;
      failures++;
      $display("FAIL %s t=%0t", nm, $time);
   endtask

   function automatic int sidx(logic [15:0] a);
      if (a < 16'h1000) return int'(a >> 2);
      else if (a == 16'h1000) return 1024;
      else return 1025;
   endfunction

   function automatic int pick();
      for (int k = 1; k <= NR; k++) begin
         int j;
         j = (ptr + k) % NR;
         if (tv[j]) return j;
      end
      return -1;
   endfunction

   function automatic int rand_waits();
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) return 0;
      if (r < 18) return $urandom_range(1, 3);
      return TO + 1;
   endfunction

   // reference model: arbitration order and expected responses
   always @(negedge pclk) begin
      int            g;
      logic [NR-1:0] er;
      exp_t          e;
      apb_t          s;
      int            w;
      if (preset) begin
         busy = 1'b0;
         eq.delete();
         ptr = NR - 1;
      end else begin
         g  = busy ? -1 : pick();
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         chk("req_ready", req_ready, er);
         if (rsp_valid != '0) begin
            if (eq.size() == 0) begin
               fail("unexpected_rsp_valid");
            end else begin
               e = eq.pop_front();
               er = '0;
               er[e.req] = 1'b1;
               chk("rsp_valid", rsp_valid, er);
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", rsp_err, e.err);
               chk("rsp_cycle", cyc, e.cyc);
            end
            busy = 1'b0;
         end
         if (g >= 0) begin
            if (spacing_chk && last_acc >= 0)
               chk("accept_spacing", cyc - last_acc, 4);
            last_acc = cyc;
            ptr = g;
            busy = 1'b1;
            w = (force_waits >= 0) ? force_waits : rand_waits();
            e.req = g;
            if (ta[g][1:0] != 2'b00) begin
               e.err = 1'b1;
               e.rdata = ERRD;
               e.cyc = cyc + 1;
            end else begin
               s.wr = tw[g];
               s.addr = ta[g];
               s.wdata = td[g];
               s.waits = w;
               s.scyc = cyc + 1;
               sq.push_back(s);
               if (w >= TO) begin
                  e.err = 1'b1;
                  e.rdata = ERRD;
                  e.cyc = cyc + 2 + TO;
               end else begin
                  e.cyc = cyc + 3 + w;
                  if (ta[g] >= 16'h1008) begin
                     e.err = 1'b1;
                     e.rdata = tw[g] ? 32'h0 : (32'hEEEE0000 | {16'h0, ta[g]});
                  end else begin
                     e.err = 1'b0;
                     if (tw[g]) begin
                        ref_mem[int'(ta[g])] = td[g];
                        e.rdata = 32'h0;
                     end else begin
                        e.rdata = ref_mem.exists(int'(ta[g])) ?
                                  ref_mem[int'(ta[g])] : 32'h0;
                     end
                  end
               end
            end
            eq.push_back(e);
         end
      end
   end

   // APB slave: RAM + two registers, programmed wait states
   always @(negedge pclk) begin
      if (preset) begin
         pready = 1'b0;
         pslverr = 1'b0;
         sq.delete();
         prev_setup = 1'b0;
      end else begin
         if (prev_setup) chk("penable_after_setup", {psel, penable}, 2'b11);
         prev_setup = 1'b0;
         pready = 1'b0;
         pslverr = 1'b0;
         prdata = $urandom;
         if (psel && !penable) begin
            if (sq.size() == 0) begin
               fail("unexpected_setup");
            end else begin
               cur = sq.pop_front();
               chk("paddr", paddr, cur.addr);
               chk("pwrite", pwrite, cur.wr);
               chk("pwdata", pwdata, cur.wdata);
               chk("setup_cycle", cyc, cur.scyc);
            end
            acc = 0;
            prev_setup = 1'b1;
         end else if (psel && penable) begin
            if (acc == cur.waits) begin
               pready = 1'b1;
               if (cur.addr >= 16'h1008) begin
                  pslverr = 1'b1;
                  if (!cur.wr) prdata = 32'hEEEE0000 | {16'h0, cur.addr};
               end else if (cur.wr) begin
                  smem[sidx(cur.addr)] = cur.wdata;
               end else begin
                  prdata = smem[sidx(cur.addr)];
               end
            end
            acc++;
         end
      end
   end

   task automatic drive(input int i);
      cmd_t c;
      bit   ok;
      while (cq[i].size() > 0) begin
         c = cq[i].pop_front();
         repeat (c.gap) begin
            @(posedge pclk);
            #1;
         end
         tv[i] = 1'b1;
         tw[i] = c.wr;
         ta[i] = c.addr;
         td[i] = c.wdata;
         ok = 1'b0;
         for (int t = 0; t < 500; t++) begin
            @(negedge pclk);
            if (req_ready[i]) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) fail("accept_timeout");
         @(posedge pclk);
         #1;
         tv[i] = 1'b0;
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(posedge pclk);
         if (eq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("drain_timeout");
      #1;
   endtask

   task automatic run_both();
      fork
         drive(0);
         drive(1);
      join
      drain();
   endtask

   function automatic cmd_t mk(logic wr, logic [15:0] a, logic [31:0] d);
      cmd_t c;
      c.wr = wr;
      c.addr = a;
      c.wdata = d;
      c.gap = 0;
      return c;
   endfunction

   function automatic logic [15:0] rand_addr();
      int r;
      logic [15:0] w;
      r = $urandom_range(0, 19);
      w = 16'($urandom_range(0, 15) * 4);
      if (r < 12) return w;
      if (r < 14) return 16'h1000;
      if (r < 15) return 16'h1004;
      if (r < 17) return w | 16'($urandom_range(1, 3));
      if (r < 18) return 16'h2000 | w;
      return w;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      cmd_t c;
      for (int i = 0; i < 1026; i++) smem[i] = '0;
      for (int i = 0; i < NR; i++) begin
         tv[i] = 1'b0;
         tw[i] = 1'b0;
         ta[i] = '0;
         td[i] = '0;
      end
      preset = 1'b1;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, 16'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_req_ready", req_ready, 2'b00);
      @(posedge pclk);
      #1;
      preset = 1'b0;

      force_waits = 0;
      cq[0].push_back(mk(1'b1, 16'h1000, 32'h5));
      cq[0].push_back(mk(1'b0, 16'h1000, 32'h0));
      run_both();

      spacing_chk = 1'b1;
      last_acc = -1;
      for (int k = 0; k < 4; k++) begin
         cq[0].push_back(mk(1'b1, 16'(k * 8), 32'hA000 + k));
         cq[1].push_back(mk(1'b1, 16'(k * 8 + 4), 32'hB000 + k));
      end
      run_both();
      spacing_chk = 1'b0;

      cq[0].push_back(mk(1'b1, 16'h0010, 32'h12345678));
      run_both();
      force_waits = 3;
      cq[0].push_back(mk(1'b0, 16'h0010, 32'h0));
      run_both();

      force_waits = 100;
      cq[1].push_back(mk(1'b0, 16'h1004, 32'h0));
      run_both();
      force_waits = 0;
      cq[1].push_back(mk(1'b0, 16'h1000, 32'h0));
      run_both();

      cq[1].push_back(mk(1'b0, 16'h1002, 32'h0));
      run_both();

      force_waits = 100;
      cq[1].push_back(mk(1'b0, 16'h0008, 32'h0));
      drive(1);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge pclk);
         if (psel && penable) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("reach_access");
      @(posedge pclk);
      #1;
      preset = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      chk("reset_psel", psel, 1'b0);
      chk("reset_penable", penable, 1'b0);
      chk("reset_rsp_valid", rsp_valid, 2'b00);
      @(posedge pclk);
      #1;
      preset = 1'b0;
      force_waits = 0;
      cq[0].push_back(mk(1'b1, 16'h0020, 32'h1));
      cq[1].push_back(mk(1'b1, 16'h0024, 32'h2));
      run_both();

      force_waits = -1;
      for (int i = 0; i < NR; i++) begin
         for (int k = 0; k < 150; k++) begin
            c.wr = 1'($urandom_range(0, 1));
            c.addr = rand_addr();
            c.wdata = $urandom;
            c.gap = $urandom_range(0, 3);
            cq[i].push_back(c);
         end
      end
      run_both();

      repeat (5) @(posedge pclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
